// File: rtl/puf_pkg.sv
// Shared definitions for the PUF measurement controller: FSM state encoding,
// settle length and a width helper.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  // Cycles allowed for the RO counter values to cross their synchroniser.
  localparam int SETTLE_CYC = 2;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/puf_meas_ctrl_counter.sv
// Up-counter with synchronous clear and a carry-out that is high while
// counting at the all-ones value.
module puf_meas_ctrl_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         up,
  output logic [W-1:0] cnt,
  output logic         rco
);

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (up) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rco = up & (&cnt);

endmodule

// File: rtl/puf_meas_ctrl.sv
// Sequences the RO-pair measurements of one challenge: clear both counters,
// count for a fixed window, let the values settle, compare, next pair.
module puf_meas_ctrl
  import puf_pkg::*;
#(
  parameter int N    = 16,
  parameter int WIN  = 1024,
  parameter int BITS = 8,
  localparam int PW  = clog2_min1(BITS),
  localparam int TW  = $clog2(WIN)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  output logic            cnt_clr,
  output logic            cnt_up,
  input  logic [N-1:0]    cnt_a,
  input  logic [N-1:0]    cnt_b,
  input  logic            rco_a,
  input  logic            rco_b,
  output logic [PW-1:0]   pair_sel,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] response,
  output logic            ovf,
  output logic            tie
);

  localparam int SW = clog2_min1(SETTLE_CYC);

  state_t          state, state_nxt;
  logic [TW-1:0]   timer_cnt;
  logic            timer_rco;
  logic [SW-1:0]   settle_cnt;
  logic            last_pair;
  logic            window_end;
  logic            settle_end;
  logic            unused_timer_rco;

  // Window timer: cleared in CLEAR, advanced in COUNT.
  puf_meas_ctrl_counter #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(clr_n),
    .clr  (cnt_clr),
    .up   (cnt_up),
    .cnt  (timer_cnt),
    .rco  (timer_rco)
  );

  // WIN need not be a power of two, so the window end is a compare, not rco.
  assign unused_timer_rco = timer_rco;

  assign last_pair  = (pair_sel == PW'(BITS - 1));
  assign window_end = (timer_cnt == TW'(WIN - 1));
  assign settle_end = (settle_cnt == SW'(SETTLE_CYC - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_up    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_clr   = 1'b1;
        state_nxt = COUNT;
      end
      COUNT: begin
        cnt_up = 1'b1;
        if (window_end) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_end) state_nxt = COMPARE;
      end
      COMPARE: begin
        state_nxt = last_pair ? DONE : CLEAR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pair_sel   <= '0;
      response   <= '0;
      ovf        <= 1'b0;
      tie        <= 1'b0;
      settle_cnt <= '0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;

      if (state == IDLE && start) begin
        pair_sel <= '0;
        response <= '0;
        ovf      <= 1'b0;
        tie      <= 1'b0;
      end

      // Overflow is only flagged; the wrapped counts are still compared.
      if (state == COUNT && (rco_a || rco_b)) begin
        ovf <= 1'b1;
      end

      if (state == COMPARE) begin
        response[pair_sel] <= (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie <= 1'b1;
        if (!last_pair) pair_sel <= pair_sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Self-checking bench for puf_meas_ctrl with behavioural RO counters whose
// per-window totals are chosen by the stimulus.
module tb_puf_meas_ctrl;

  localparam int N       = 8;
  localparam int WIN     = 16;
  localparam int BITS    = 4;
  localparam int RUN_LEN = BITS * (WIN + 4) + 1;
  localparam int MODV    = 1 << N;

  typedef struct packed {
    logic [BITS-1:0][9:0] ta;
    logic [BITS-1:0][9:0] tb;
    logic [BITS-1:0]      resp;
    logic                 ovf;
    logic                 tie;
  } vec_t;

  logic            clk = 1'b0;
  logic            clr_n = 1'b0;
  logic            start = 1'b0;
  logic            cnt_clr, cnt_up, busy, done, ovf, tie, rco_a, rco_b;
  logic [N-1:0]    cnt_a, cnt_b;
  logic [1:0]      pair_sel;
  logic [BITS-1:0] response;

  int pass_cnt = 0;
  int total_cnt = 0;
  int tgt_a[BITS];
  int tgt_b[BITS];
  int acc_a = 0, acc_b = 0, wi = 0;
  int done_cnt = 0, overlap = 0, up_run = 0;

  puf_meas_ctrl #(.N(N), .WIN(WIN), .BITS(BITS)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .cnt_clr (cnt_clr),
    .cnt_up  (cnt_up),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .rco_a   (rco_a),
    .rco_b   (rco_b),
    .pair_sel(pair_sel),
    .busy    (busy),
    .done    (done),
    .response(response),
    .ovf     (ovf),
    .tie     (tie)
  );

  always #5 clk = ~clk;

  // Spreads a window total t evenly over the WIN enabled cycles.
  function automatic int step(input int t, input int i);
    return (t * (i + 1)) / WIN - (t * i) / WIN;
  endfunction

  assign cnt_a = N'(acc_a % MODV);
  assign cnt_b = N'(acc_b % MODV);
  assign rco_a = cnt_up && ((acc_a % MODV) + step(tgt_a[pair_sel], wi) >= MODV);
  assign rco_b = cnt_up && ((acc_b % MODV) + step(tgt_b[pair_sel], wi) >= MODV);

  always @(posedge clk) begin
    if (cnt_clr) begin
      acc_a <= 0;
      acc_b <= 0;
      wi    <= 0;
    end else if (cnt_up) begin
      acc_a <= acc_a + step(tgt_a[pair_sel], wi);
      acc_b <= acc_b + step(tgt_b[pair_sel], wi);
      wi    <= wi + 1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (cnt_clr && cnt_up) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!clr_n) begin
      up_run <= 0;
    end else if (cnt_up) begin
      up_run <= up_run + 1;
    end else if (up_run != 0) begin
      check("cnt_up_run_len", up_run, WIN);
      up_run <= 0;
    end
  end

  task automatic load(input vec_t v);
    for (int i = 0; i < BITS; i++) begin
      tgt_a[i] = int'(v.ta[i]);
      tgt_b[i] = int'(v.tb[i]);
    end
  endtask

  // Expected result straight from the rules: compare wrapped totals, flag
  // equal totals as ties and any total past the counter range as overflow.
  task automatic ref_model(output logic [BITS-1:0] r, output logic o, output logic t);
    r = '0;
    o = 1'b0;
    t = 1'b0;
    for (int i = 0; i < BITS; i++) begin
      r[i] = (tgt_a[i] % MODV) > (tgt_b[i] % MODV);
      if ((tgt_a[i] % MODV) == (tgt_b[i] % MODV)) t = 1'b1;
      if (tgt_a[i] >= MODV || tgt_b[i] >= MODV) o = 1'b1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run; lat is the cycle (1 = first after the accepting edge) of done.
  task automatic run(output logic [BITS-1:0] r, output logic o, output logic t,
                     output int lat);
    pulse_start();
    lat = 1;
    check("busy_after_start", busy, 1);
    while (!done && lat < 4 * RUN_LEN) begin
      @(negedge clk);
      lat++;
    end
    r = response;
    o = ovf;
    t = tie;
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_result(input string tag, input logic [BITS-1:0] r, input logic o,
                              input logic t, input int lat, input logic [BITS-1:0] er,
                              input logic eo, input logic et);
    check({tag, "_latency"}, lat, RUN_LEN);
    check({tag, "_response"}, r, er);
    check({tag, "_ovf"}, o, eo);
    check({tag, "_tie"}, t, et);
  endtask

  vec_t            vecs[3];
  logic [BITS-1:0] r, er;
  logic            o, t, eo, et;
  int              lat, c, d0, done_at;

  initial begin
    vecs[0] = '{ta: {10'd30, 10'd180, 10'd50, 10'd200}, tb: {10'd120, 10'd60, 10'd90, 10'd100},
                resp: 4'b0101, ovf: 1'b0, tie: 1'b0};
    vecs[1] = '{ta: {10'd5, 10'd40, 10'd10, 10'd70}, tb: {10'd8, 10'd90, 10'd10, 10'd20},
                resp: 4'b0001, ovf: 1'b0, tie: 1'b1};
    vecs[2] = '{ta: {10'd300, 10'd200, 10'd30, 10'd120}, tb: {10'd90, 10'd100, 10'd80, 10'd60},
                resp: 4'b0101, ovf: 1'b1, tie: 1'b0};
    load(vecs[0]);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    check("rst_cnt_up", cnt_up, 0);
    check("rst_pair_sel", pair_sel, 0);
    check("rst_response", response, 0);
    check("rst_ovf_tie", {ovf, tie}, 0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors
    for (int k = 0; k < 3; k++) begin
      load(vecs[k]);
      run(r, o, t, lat);
      check_result($sformatf("vec%0d", k), r, o, t, lat, vecs[k].resp, vecs[k].ovf, vecs[k].tie);
    end

    // Randomised runs against the reference model
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < BITS; i++) begin
        tgt_a[i] = int'($urandom_range(0, MODV - 1));
        tgt_b[i] = ($urandom_range(0, 3) == 0) ? tgt_a[i] : int'($urandom_range(0, MODV - 1));
      end
      ref_model(er, eo, et);
      run(r, o, t, lat);
      check_result($sformatf("rand%0d", k), r, o, t, lat, er, eo, et);
    end

    // start re-pulsed mid-run is ignored; exactly one done at the usual cycle
    load(vecs[0]);
    d0 = done_cnt;
    done_at = -1;
    pulse_start();
    c = 1;
    while (c < RUN_LEN + 20) begin
      @(negedge clk);
      c++;
      start = (c == 30);
      if (done) done_at = c;
    end
    check("repulse_done_at", done_at, RUN_LEN);
    check("repulse_done_count", done_cnt - d0, 1);
    check("repulse_response", response, 4'b0101);

    // Reset mid-run aborts with no done; next start runs fresh
    pulse_start();
    c = 1;
    while (c < 40) begin
      @(negedge clk);
      c++;
    end
    check("pre_reset_response", response, 4'b0001);
    clr_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt_ctl", {cnt_clr, cnt_up}, 0);
    check("midrst_pair_sel", pair_sel, 0);
    check("midrst_response", response, 0);
    check("midrst_ovf_tie", {ovf, tie}, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
    load(vecs[1]);
    run(r, o, t, lat);
    check_result("post_rst", r, o, t, lat, vecs[1].resp, vecs[1].ovf, vecs[1].tie);

    // start held across DONE re-triggers from IDLE on the following edge
    load(vecs[2]);
    pulse_start();
    c = 1;
    while (!done && c < 4 * RUN_LEN) begin
      @(negedge clk);
      c++;
    end
    check("hold_first_done", c, RUN_LEN);
    start = 1'b1;
    @(negedge clk);
    check("hold_idle_gap", busy, 0);
    @(negedge clk);
    check("hold_retrigger", busy, 1);
    check("hold_cleared", {response, ovf, tie}, 0);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 4 * RUN_LEN) begin
      @(negedge clk);
      lat++;
    end
    check_result("hold_second", response, ovf, tie, lat, vecs[2].resp, vecs[2].ovf,
                 vecs[2].tie);

    repeat (3) @(negedge clk);
    check("no_clr_up_overlap", overlap, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
